ula_arb: RTL and testbench

ULA_ARB -- requirements
Module: ula_arb

---
 rtl/ula_arb.sv | 125 ++++++++++++
 tb/tb_ula_arb.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ula_arb.sv
// Two-requester arbiter in front of a shared combinational ULA: accept, execute, respond.
// Define ULA_ARB_RR_EN for round-robin arbitration; the default is fixed priority with requester 0 first.
module ula_arb #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned OPW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req1_op,
  output logic [WIDTH-1:0] ula_a,
  output logic [WIDTH-1:0] ula_b,
  output logic [OPW-1:0]   ula_op,
  input  logic [WIDTH-1:0] ula_resu,
  input  logic             ula_o,
  input  logic             ula_c,
  input  logic             ula_s,
  input  logic             ula_z,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_resu,
  output logic [3:0]       rsp_flags
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [OPW-1:0]   r_op;
  logic             r_id;
  logic             r_rsp_valid;
  logic [WIDTH-1:0] r_resu;
  logic [3:0]       r_flags;

  logic w_idle;
  logic w_gnt0;
  logic w_accept;

`ifdef ULA_ARB_RR_EN
  logic r_ptr;

  // r_ptr names the preferred requester on a tie
  assign w_gnt0 = req0_valid & (~req1_valid | ~r_ptr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= 1'b0;
    end else if (w_accept) begin
      r_ptr <= req0_ready;
    end
  end
`else
  assign w_gnt0 = req0_valid;
`endif

  // Grants are visible only in IDLE and are held off while reset is asserted
  assign w_idle     = rst_n & (r_state == IDLE);
  assign req0_ready = w_idle & w_gnt0;
  assign req1_ready = w_idle & req1_valid & ~w_gnt0;
  assign w_accept   = req0_ready | req1_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= '0;
      r_id        <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_resu      <= '0;
      r_flags     <= 4'b0000;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a     <= req1_ready ? req1_a  : req0_a;
            r_b     <= req1_ready ? req1_b  : req0_b;
            r_op    <= req1_ready ? req1_op : req0_op;
            r_id    <= req1_ready;
            r_state <= EXEC;
          end
        end
        EXEC: begin
          r_resu      <= ula_resu;
          r_flags     <= {ula_o, ula_c, ula_s, ula_z};
          r_rsp_valid <= 1'b1;
          r_state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign ula_a     = r_a;
  assign ula_b     = r_b;
  assign ula_op    = r_op;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_id;
  assign rsp_resu  = r_resu;
  assign rsp_flags = r_flags;

endmodule

// File: tb/tb_ula_arb.sv
// Scoreboard bench for ula_arb with a behavioural ULA, arbitration model and random traffic.
module tb_ula_arb;

  localparam int unsigned W   = 3;
  localparam int unsigned OPW = 5;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           req0_valid = 1'b0, req1_valid = 1'b0;
  logic           req0_ready, req1_ready;
  logic [W-1:0]   req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [OPW-1:0] req0_op = '0, req1_op = '0;
  logic [W-1:0]   ula_a, ula_b, ula_resu;
  logic [OPW-1:0] ula_op;
  logic           ula_o, ula_c, ula_s, ula_z;
  logic           rsp_valid, rsp_id;
  logic           rsp_ready = 1'b0;
  logic [W-1:0]   rsp_resu;
  logic [3:0]     rsp_flags;

  ula_arb #(.WIDTH(W), .OPW(OPW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .ula_a(ula_a), .ula_b(ula_b), .ula_op(ula_op),
    .ula_resu(ula_resu), .ula_o(ula_o), .ula_c(ula_c), .ula_s(ula_s), .ula_z(ula_z),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_resu(rsp_resu), .rsp_flags(rsp_flags)
  );

  always #5 clk = ~clk;

  // Returns {result, O, C, S, Z}
  function automatic logic [W+3:0] ula_ref(input logic [OPW-1:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic [W:0]   t;
    logic         o;
    logic [W-1:0] r;
    t = '0;
    o = 1'b0;
    case (op)
      5'd0: begin t = {1'b0, a} + {1'b0, b}; o = (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]); end
      5'd1: begin t = {1'b0, a} - {1'b0, b}; o = (a[W-1] != b[W-1]) && (t[W-1] != a[W-1]); end
      5'd2: t = {1'b0, a & b};
      5'd3: begin t = {1'b0, a} + (W+1)'(1); o = !a[W-1] && t[W-1]; end
      default: t = {1'b0, a ^ b};
    endcase
    r = t[W-1:0];
    return {r, o, t[W], r[W-1], (r == '0)};
  endfunction

  always_comb {ula_resu, ula_o, ula_c, ula_s, ula_z} = ula_ref(ula_op, ula_a, ula_b);

  typedef struct packed {
    logic         id;
    logic [W-1:0] res;
    logic [3:0]   flg;
  } exp_t;

  exp_t q[$];
  int   n_pass = 0, n_total = 0;

  // Requester-side state: pending request, payload, optional directed expectation
  bit             pend[2];
  bit             dh[2];
  logic [W-1:0]   pa[2], pb[2], dres[2];
  logic [OPW-1:0] pop[2];
  logic [3:0]     dflg[2];
  int             prob[2];
  int             force_rr = 1;

  // Reference model: busy from acceptance until the response handshake
  bit m_busy = 0;
  bit m_ptr = 0;
  int m_acc = 0;
  int cyc = 0;
  bit rec = 0;
  int acc_cyc[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic issue(input int id, input logic [OPW-1:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input bit has, input logic [W-1:0] er,
                       input logic [3:0] ef);
    pend[id] = 1; pop[id] = op; pa[id] = a; pb[id] = b;
    dh[id] = has; dres[id] = er; dflg[id] = ef;
  endtask

  task automatic step();
    int   w;
    bit   e0, e1, ev;
    exp_t e;
    logic [W+3:0] rf;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      if (!pend[i] && $urandom_range(0, 99) < prob[i])
        issue(i, OPW'($urandom_range(0, 4)), W'($urandom), W'($urandom), 0, '0, '0);
    end
    req0_valid = pend[0]; req0_a = pa[0]; req0_b = pb[0]; req0_op = pop[0];
    req1_valid = pend[1]; req1_a = pa[1]; req1_b = pb[1]; req1_op = pop[1];
    rsp_ready = (force_rr == 2) ? ($urandom_range(0, 99) < 60) : (force_rr == 1);
    #2;
    w = -1;
    if (!m_busy) begin
      if (pend[0] && pend[1]) begin
`ifdef ULA_ARB_RR_EN
        w = int'(m_ptr);
`else
        w = 0;
`endif
      end else if (pend[0]) w = 0;
      else if (pend[1]) w = 1;
    end
    e0 = (w == 0);
    e1 = (w == 1);
    ev = m_busy && (cyc >= m_acc + 2);
    check("req0_ready", 32'(req0_ready), 32'(e0));
    check("req1_ready", 32'(req1_ready), 32'(e1));
    check("rsp_valid", 32'(rsp_valid), 32'(ev));
    if (rec && req0_ready) acc_cyc.push_back(cyc);
    if (w >= 0) begin
      rf = ula_ref(pop[w], pa[w], pb[w]);
      e.id  = (w == 1);
      e.res = dh[w] ? dres[w] : rf[W+3:4];
      e.flg = dh[w] ? dflg[w] : rf[3:0];
      q.push_back(e);
      pend[w] = 0;
      m_busy = 1;
      m_acc = cyc;
      m_ptr = (w == 0);
    end else if (ev && rsp_ready) begin
      m_busy = 0;
    end
    cyc++;
  endtask

  task automatic run_until_idle();
    int n = 0;
    while ((m_busy || pend[0] || pend[1]) && n < 60) begin
      step();
      n++;
    end
    check("drain_in_budget", 32'(m_busy || pend[0] || pend[1]), 32'(0));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    check("rst_req0_ready", 32'(req0_ready), 32'(0));
    check("rst_req1_ready", 32'(req1_ready), 32'(0));
    check("rst_ula_a", 32'(ula_a), 32'(0));
    check("rst_ula_b", 32'(ula_b), 32'(0));
    check("rst_ula_op", 32'(ula_op), 32'(0));
    check("rst_rsp_resu", 32'(rsp_resu), 32'(0));
    check("rst_rsp_flags", 32'(rsp_flags), 32'(0));
    check("rst_rsp_id", 32'(rsp_id), 32'(0));
    q.delete();
    m_busy = 0;
    m_ptr = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Monitor: every presented response must match the oldest outstanding expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (rst_n && rsp_valid) begin
        if (q.size() == 0) begin
          check("rsp_spurious", 32'(rsp_valid), 32'(0));
        end else begin
          e = q[0];
          check("rsp_id", 32'(rsp_id), 32'(e.id));
          check("rsp_resu", 32'(rsp_resu), 32'(e.res));
          check("rsp_flags", 32'(rsp_flags), 32'(e.flg));
          if (rsp_ready) void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      pend[i] = 0; dh[i] = 0; pa[i] = '0; pb[i] = '0; pop[i] = '0;
      dres[i] = '0; dflg[i] = '0; prob[i] = 0;
    end
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    do_reset();

    // Add with carry out to zero
    force_rr = 1;
    issue(0, 5'd0, 3'b001, 3'b111, 1, 3'b000, 4'b0101);
    run_until_idle();

    // Tie: req0 first, then req1 (or a re-asserted req0 under fixed priority)
    issue(0, 5'd0, 3'b010, 3'b011, 1, 3'b101, 4'b1010);
    issue(1, 5'd3, 3'b111, 3'b000, 1, 3'b000, 4'b0101);
    step();
    issue(0, 5'd2, 3'b110, 3'b011, 0, '0, '0);
    run_until_idle();

    // Consumer stalls in RESP while req1 waits
    issue(0, 5'd1, 3'b011, 3'b101, 0, '0, '0);
    issue(1, 5'd4, 3'b110, 3'b010, 0, '0, '0);
    force_rr = 0;
    repeat (8) step();
    force_rr = 1;
    run_until_idle();

    // Reset during EXEC discards the operation
    issue(0, 5'd1, 3'b101, 3'b110, 0, '0, '0);
    step();
    @(posedge clk);
    #3;
    do_reset();
    issue(1, 5'd0, 3'b011, 3'b001, 1, 3'b100, 4'b1010);
    run_until_idle();

    // Back-to-back single requester with the consumer always ready
    prob[0] = 100; prob[1] = 0; rec = 1;
    repeat (30) step();
    rec = 0; prob[0] = 0;
    run_until_idle();
    check("b2b_count", 32'(acc_cyc.size() >= 9), 32'(1));
    for (int i = 1; i < acc_cyc.size(); i++)
      check("b2b_spacing", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'(3));

    // Both requesters continuously busy
    prob[0] = 100; prob[1] = 100;
    repeat (24) step();

    // Random traffic with random consumer back-pressure
    prob[0] = 50; prob[1] = 50; force_rr = 2;
    repeat (1500) step();

    prob[0] = 0; prob[1] = 0; force_rr = 1;
    run_until_idle();
    repeat (3) step();
    check("queue_empty", 32'(q.size()), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
